mem_dma: RTL and testbench

//  Bus initiator for the Hack memory map (RAM 0x0000-0x3FFF, screen 0x4000-0x5FFF, kbd 0x6000).

---
 rtl/mem_dma_pkg.sv | 22 ++
 rtl/mem_dma_if.sv | 30 +++
 rtl/mem_dma.sv | 91 +++++++++
 tb/tb_mem_dma.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dma_pkg.sv
// Shared constants for the Hack memory-map DMA engine: widths, memory map and FSM encodings.
package mem_dma_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 15;

    localparam logic [15:0] RAM_TOP     = 16'h3FFF;
    localparam logic [15:0] SCREEN_BASE = 16'h4000;
    localparam logic [15:0] KBD_ADDR    = 16'h6000;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_LAT  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [LEN_W-1:0]  len_t;

endpackage

// File: rtl/mem_dma_if.sv
// Command and memory-bus signals of the DMA engine; master is the DMA side, slave the environment.
interface mem_dma_if #(
    parameter int unsigned ADDR_WIDTH = mem_dma_pkg::ADDR_W,
    parameter int unsigned DATA_WIDTH = mem_dma_pkg::DATA_W,
    parameter int unsigned LEN_WIDTH  = mem_dma_pkg::LEN_W
) ();

    logic                  start;
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [LEN_WIDTH-1:0]  len;
    logic                  active;
    logic                  done;
    logic                  mem_load;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_in;
    logic                  mem_busy;
    logic [DATA_WIDTH-1:0] mem_out;

    modport master (
        input  start, src, dst, len, mem_busy, mem_out,
        output active, done, mem_load, mem_address, mem_in
    );

    modport slave (
        output start, src, dst, len, mem_busy, mem_out,
        input  active, done, mem_load, mem_address, mem_in
    );

endinterface

// File: rtl/mem_dma.sv
// Word-copy engine: reads src, waits one cycle for read data, writes dst; repeats len times.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = mem_dma_pkg::ADDR_W,
    parameter int unsigned DATA_WIDTH = mem_dma_pkg::DATA_W,
    parameter int unsigned LEN_WIDTH  = mem_dma_pkg::LEN_W
) (
    input  logic      i_clk,
    input  logic      i_reset,
    mem_dma_if.master io_bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = '0;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  w_accept;
    logic                  w_take;

    assign w_accept = (r_state == ST_IDLE) && io_bus.start && (io_bus.len != LEN_ZERO);
    // A write only completes when memory is not busy; otherwise WR holds everything.
    assign w_take   = (r_state == ST_WR) && !io_bus.mem_busy;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.start) begin
                    w_state_nxt = (io_bus.len != LEN_ZERO) ? ST_RD : ST_FIN;
                end
            end
            ST_RD:   w_state_nxt = ST_LAT;
            ST_LAT:  w_state_nxt = ST_WR;
            ST_WR: begin
                if (!io_bus.mem_busy) begin
                    w_state_nxt = (r_cnt == LEN_ONE) ? ST_FIN : ST_RD;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_src <= io_bus.src;
                r_dst <= io_bus.dst;
                r_cnt <= io_bus.len;
            end
            // Read data is valid in the cycle after the address, i.e. during LAT.
            if (r_state == ST_LAT) begin
                r_buf <= io_bus.mem_out;
            end
            if (w_take) begin
                r_src <= r_src + ADDR_ONE;
                r_dst <= r_dst + ADDR_ONE;
                r_cnt <= r_cnt - LEN_ONE;
            end
        end
    end

    assign io_bus.active   = (r_state == ST_RD) || (r_state == ST_LAT) || (r_state == ST_WR);
    assign io_bus.done     = (r_state == ST_FIN);
    assign io_bus.mem_load = (r_state == ST_WR);
    assign io_bus.mem_in   = r_buf;

    always_comb begin
        io_bus.mem_address = '0;
        if (r_state == ST_WR) begin
            io_bus.mem_address = r_dst;
        end else if ((r_state == ST_RD) || (r_state == ST_LAT)) begin
            io_bus.mem_address = r_src;
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a 1-cycle-latency behavioural memory and driveable busy.
module tb_mem_dma;
    import mem_dma_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_dma_if #(.ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .LEN_WIDTH(LEN_W)) bus ();

    mem_dma #(.ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .LEN_WIDTH(LEN_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    logic [15:0] mem [0:65535];
    logic [15:0] rd_q;
    logic [15:0] prev_addr;
    logic        garbage;

    // In garbage mode read data is only valid once the address has been held for a cycle.
    assign bus.mem_out = (garbage && (prev_addr != bus.mem_address)) ? 16'hDEAD : rd_q;

    int n_total;
    int n_bad;
    int n_load;
    int n_done;
    int n_active;
    int n_wr;

    task automatic step();
        logic [15:0] nxt;
        logic [15:0] a;
        if (bus.mem_load) n_load++;
        if (bus.done) n_done++;
        if (bus.active) n_active++;
        if (bus.mem_load && !bus.mem_busy) begin
            n_wr++;
            if (bus.mem_address != KBD_ADDR) mem[bus.mem_address] = bus.mem_in;
        end
        a   = bus.mem_address;
        nxt = mem[a];
        @(posedge clk);
        #1;
        rd_q      = nxt;
        prev_addr = a;
    endtask

    task automatic clear_counts();
        n_load   = 0;
        n_done   = 0;
        n_active = 0;
        n_wr     = 0;
    endtask

    task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [14:0] l);
        bus.start = 1'b1;
        bus.src   = s;
        bus.dst   = d;
        bus.len   = l;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.len = 15'd3;
        step();
        step();
        bus.start = 1'b0;
        n_total++;
        if (bus.active !== 1'b0) begin
            n_bad++; $display("FAIL reset_active got=%b want=0", bus.active);
        end
        n_total++;
        if (bus.done !== 1'b0) begin
            n_bad++; $display("FAIL reset_done got=%b want=0", bus.done);
        end
        n_total++;
        if (bus.mem_load !== 1'b0) begin
            n_bad++; $display("FAIL reset_load got=%b want=0", bus.mem_load);
        end
        n_total++;
        if (bus.mem_address !== 16'h0000) begin
            n_bad++; $display("FAIL reset_addr got=%h want=0000", bus.mem_address);
        end
        n_total++;
        if (bus.mem_in !== 16'h0000) begin
            n_bad++; $display("FAIL reset_in got=%h want=0000", bus.mem_in);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_copy();
        int n;
        for (int i = 0; i < 4; i++) begin
            mem[16'h0010 + 16'(i)] = 16'(i + 1);
            mem[16'h0100 + 16'(i)] = 16'h0000;
        end
        clear_counts();
        issue(16'h0010, 16'h0100, 15'd4);
        n = 1;
        while (!bus.done && n < 100) begin
            step();
            n++;
        end
        n_total++;
        if (n !== 13) begin
            n_bad++; $display("FAIL copy_latency got=%0d want=13", n);
        end
        n_total++;
        if (n_load !== 4) begin
            n_bad++; $display("FAIL copy_load_cycles got=%0d want=4", n_load);
        end
        n_total++;
        if (bus.active !== 1'b0) begin
            n_bad++; $display("FAIL copy_active_at_done got=%b want=0", bus.active);
        end
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (mem[16'h0100 + 16'(i)] !== 16'(i + 1)) begin
                n_bad++;
                $display("FAIL copy_data[%0d] got=%h want=%h", i, mem[16'h0100 + 16'(i)], i + 1);
            end
        end
        step();
        n_total++;
        if (bus.done !== 1'b0) begin
            n_bad++; $display("FAIL copy_done_pulse got=%b want=0", bus.done);
        end
    endtask

    task automatic test_len0();
        clear_counts();
        issue(16'h0010, 16'h0100, 15'd0);
        n_total++;
        if (bus.done !== 1'b1) begin
            n_bad++; $display("FAIL len0_done got=%b want=1", bus.done);
        end
        step();
        n_total++;
        if (bus.done !== 1'b0) begin
            n_bad++; $display("FAIL len0_done_pulse got=%b want=0", bus.done);
        end
        n_total++;
        if (n_active !== 0 || n_load !== 0) begin
            n_bad++; $display("FAIL len0_quiet active=%0d load=%0d want=0/0", n_active, n_load);
        end
    endtask

    task automatic test_stall();
        int n;
        mem[16'h0020] = 16'hBEEF;
        mem[SCREEN_BASE] = 16'h0000;
        clear_counts();
        issue(16'h0020, SCREEN_BASE, 15'd1);
        step();
        step();
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.mem_busy = 1'b0;
            n_total++;
            if ({bus.mem_address, bus.mem_in, bus.mem_load} !== {SCREEN_BASE, 16'hBEEF, 1'b1}) begin
                n_bad++;
                $display("FAIL stall_hold[%0d] got=%h/%h/%b want=%h/beef/1", i,
                         bus.mem_address, bus.mem_in, bus.mem_load, SCREEN_BASE);
            end
            step();
        end
        n = 9;
        while (!bus.done && n < 60) begin
            step();
            n++;
        end
        n_total++;
        if (n !== 9) begin
            n_bad++; $display("FAIL stall_latency got=%0d want=9", n);
        end
        n_total++;
        if (n_wr !== 1 || mem[SCREEN_BASE] !== 16'hBEEF) begin
            n_bad++; $display("FAIL stall_write got=%0d/%h want=1/beef", n_wr, mem[SCREEN_BASE]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        mem[16'h0030] = 16'h00A1;
        mem[16'h0031] = 16'h00A2;
        mem[16'h0032] = 16'h00A3;
        for (int i = 0; i < 3; i++) mem[RAM_TOP - 16'd2 + 16'(i)] = 16'h0000;
        issue(16'h0030, RAM_TOP - 16'd2, 15'd3);
        for (int i = 0; i < 5; i++) step();
        n_total++;
        if (bus.mem_load !== 1'b1) begin
            n_bad++; $display("FAIL rmid_second_wr got=%b want=1", bus.mem_load);
        end
        bus.mem_busy = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.mem_busy = 1'b0;
        n_total++;
        if (bus.mem_load !== 1'b0 || bus.active !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_after got=%b/%b/%b want=0/0/0", bus.mem_load, bus.active, bus.done);
        end
        clear_counts();
        for (int i = 0; i < 12; i++) step();
        n_total++;
        if (n_done !== 0 || n_load !== 0) begin
            n_bad++; $display("FAIL rmid_quiet done=%0d load=%0d want=0/0", n_done, n_load);
        end
        n_total++;
        if ({mem[RAM_TOP - 16'd2], mem[RAM_TOP - 16'd1], mem[RAM_TOP]} !== 48'h00A1_0000_0000) begin
            n_bad++;
            $display("FAIL rmid_mem got=%h %h %h want=00a1 0000 0000", mem[RAM_TOP - 16'd2],
                     mem[RAM_TOP - 16'd1], mem[RAM_TOP]);
        end
    endtask

    task automatic test_wrap_ignore();
        int done_at;
        mem[16'hFFFF] = 16'h1111;
        mem[16'h0000] = 16'h2222;
        for (int i = 0; i < 3; i++) mem[16'h0200 + 16'(i)] = 16'h0000;
        mem[16'h0600] = 16'h0000;
        done_at = 0;
        clear_counts();
        issue(16'hFFFF, 16'h0200, 15'd2);
        for (int n = 1; n <= 20; n++) begin
            if (n == 1) begin
                n_total++;
                if (bus.mem_address !== 16'hFFFF) begin
                    n_bad++; $display("FAIL wrap_rd0 got=%h want=ffff", bus.mem_address);
                end
            end
            if (n == 2) begin
                bus.start = 1'b1;
                bus.src   = 16'h0050;
                bus.dst   = 16'h0600;
                bus.len   = 15'd5;
            end
            if (n == 3) bus.start = 1'b0;
            if (n == 4) begin
                n_total++;
                if (bus.mem_address !== 16'h0000) begin
                    n_bad++; $display("FAIL wrap_rd1 got=%h want=0000", bus.mem_address);
                end
            end
            if (n == 6) begin
                n_total++;
                if (bus.mem_address !== 16'h0201) begin
                    n_bad++; $display("FAIL wrap_wr1 got=%h want=0201", bus.mem_address);
                end
            end
            if (bus.done && done_at == 0) done_at = n;
            step();
        end
        n_total++;
        if (done_at !== 7 || n_done !== 1) begin
            n_bad++; $display("FAIL wrap_done at=%0d count=%0d want=7/1", done_at, n_done);
        end
        n_total++;
        if ({mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0600]}
            !== 64'h1111_2222_0000_0000) begin
            n_bad++;
            $display("FAIL wrap_mem got=%h %h %h %h want=1111 2222 0000 0000", mem[16'h0200],
                     mem[16'h0201], mem[16'h0202], mem[16'h0600]);
        end
    endtask

    task automatic test_read_latency();
        int n;
        mem[16'h0040] = 16'h5A5A;
        mem[16'h0500] = 16'h0000;
        garbage = 1'b1;
        issue(16'h0040, 16'h0500, 15'd1);
        n = 1;
        while (!bus.done && n < 40) begin
            step();
            n++;
        end
        garbage = 1'b0;
        n_total++;
        if (n !== 4) begin
            n_bad++; $display("FAIL lat_done got=%0d want=4", n);
        end
        n_total++;
        if (mem[16'h0500] !== 16'h5A5A) begin
            n_bad++; $display("FAIL lat_capture got=%h want=5a5a", mem[16'h0500]);
        end
        step();
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        garbage      = 1'b0;
        prev_addr    = 16'h0000;
        rd_q         = 16'h0000;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.src      = 16'h0000;
        bus.dst      = 16'h0000;
        bus.len      = 15'd0;
        bus.mem_busy = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        clear_counts();
        @(posedge clk);
        #1;
        test_reset();
        test_copy();
        test_len0();
        test_stall();
        test_reset_mid();
        test_wrap_ignore();
        test_read_latency();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
